// File: rtl/memory_interface_if.sv
// Bundles the load/store sequencer request signals and the external bus
// signals of memory_interface into a single port.
interface memory_interface_if;
    logic        reqValid;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] address;
    logic [1:0]  dataSelectBits;
    logic [31:0] writeData;
    logic [31:0] busReadData;
    logic        busReady;
    logic [31:0] busAddress;
    logic [3:0]  busByteEnable;
    logic [31:0] busWriteData;
    logic        busRead;
    logic        busWrite;
    logic        busy;
    logic        done;
    logic [31:0] loadData;
    logic        alignFault;
    logic        busFault;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, address, dataSelectBits,
               writeData, busReadData, busReady,
        output busAddress, busByteEnable, busWriteData, busRead, busWrite,
               busy, done, loadData, alignFault, busFault
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, address, dataSelectBits,
               writeData, busReadData, busReady,
        input  busAddress, busByteEnable, busWriteData, busRead, busWrite,
               busy, done, loadData, alignFault, busFault
    );
endinterface

// File: rtl/memory_interface.sv
// Load/store bus access unit: alignment checking, byte-lane steering,
// load extension and a bounded wait for bus completion.
module memory_interface #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    memory_interface_if.slave   bus
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RESPOND = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [31:0] bus_address_q, bus_address_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_read_q, bus_read_d;
    logic        bus_write_q, bus_write_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] load_data_q, load_data_d;
    logic        align_fault_q, align_fault_d;
    logic        bus_fault_q, bus_fault_d;

    // Low address bits are deliberately ignored; the offset comes from dataSelectBits.
    logic unused_addr_lsb_s;
    assign unused_addr_lsb_s = ^bus.address[1:0];

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = off[0];
            2'b10:   r = (off != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] r;
        case (size)
            2'b00:   r = 4'b0001 << off;
            2'b01:   r = off[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{data[7:0]}};
            2'b01:   r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [1:0] size, input logic [1:0] off,
                                                 input logic sgn, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        size_d        = size_q;
        off_d         = off_q;
        signed_d      = signed_q;
        write_d       = write_q;
        bus_address_d = bus_address_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        bus_read_d    = bus_read_q;
        bus_write_d   = bus_write_q;
        load_data_d   = load_data_q;
        done_d        = 1'b0;
        align_fault_d = 1'b0;
        bus_fault_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.reqValid) begin
                    if (is_misaligned(bus.reqSize, bus.dataSelectBits)) begin
                        align_fault_d = 1'b1;
                        done_d        = 1'b1;
                    end else begin
                        state_d       = ACCESS;
                        wait_d        = 8'd0;
                        size_d        = bus.reqSize;
                        off_d         = bus.dataSelectBits;
                        signed_d      = bus.reqSigned;
                        write_d       = bus.reqWrite;
                        bus_address_d = {bus.address[31:2], 2'b00};
                        bus_be_d      = byte_enable(bus.reqSize, bus.dataSelectBits);
                        bus_wdata_d   = replicate_wdata(bus.reqSize, bus.writeData);
                        bus_read_d    = ~bus.reqWrite;
                        bus_write_d   = bus.reqWrite;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Completion wins over a timeout reached in the same cycle.
                if (bus.busReady) begin
                    state_d     = RESPOND;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    if (!write_q) begin
                        load_data_d = extract_load(size_q, off_q, signed_q, bus.busReadData);
                    end else begin
                        load_data_d = load_data_q;
                    end
                end else if ((wait_q + 8'd1) == TIMEOUT_C) begin
                    state_d     = IDLE;
                    wait_d      = wait_q + 8'd1;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    bus_fault_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESPOND: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                bus_read_d  = 1'b0;
                bus_write_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            wait_q        <= 8'd0;
            size_q        <= 2'b00;
            off_q         <= 2'b00;
            signed_q      <= 1'b0;
            write_q       <= 1'b0;
            bus_address_q <= 32'd0;
            bus_be_q      <= 4'd0;
            bus_wdata_q   <= 32'd0;
            bus_read_q    <= 1'b0;
            bus_write_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            load_data_q   <= 32'd0;
            align_fault_q <= 1'b0;
            bus_fault_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            size_q        <= size_d;
            off_q         <= off_d;
            signed_q      <= signed_d;
            write_q       <= write_d;
            bus_address_q <= bus_address_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_read_q    <= bus_read_d;
            bus_write_q   <= bus_write_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            load_data_q   <= load_data_d;
            align_fault_q <= align_fault_d;
            bus_fault_q   <= bus_fault_d;
        end
    end

    assign bus.busAddress    = bus_address_q;
    assign bus.busByteEnable = bus_be_q;
    assign bus.busWriteData  = bus_wdata_q;
    assign bus.busRead       = bus_read_q;
    assign bus.busWrite      = bus_write_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.loadData      = load_data_q;
    assign bus.alignFault    = align_fault_q;
    assign bus.busFault      = bus_fault_q;

endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface with TIMEOUT=4; expected values are
// worked out by hand from the access protocol.
module tb_memory_interface;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    memory_interface_if bus_if ();

    memory_interface #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus_if.reqValid       = 1'b0;
        bus_if.reqWrite       = 1'b0;
        bus_if.reqSize        = 2'b00;
        bus_if.reqSigned      = 1'b0;
        bus_if.address        = 32'd0;
        bus_if.dataSelectBits = 2'b00;
        bus_if.writeData      = 32'd0;
        bus_if.busReadData    = 32'd0;
        bus_if.busReady       = 1'b0;
        tick();
        tick();
        chk("rst_busy",   32'(bus_if.busy),          32'd0);
        chk("rst_done",   32'(bus_if.done),          32'd0);
        chk("rst_load",   bus_if.loadData,           32'd0);
        chk("rst_rd",     32'(bus_if.busRead),       32'd0);
        chk("rst_wr",     32'(bus_if.busWrite),      32'd0);
        chk("rst_addr",   bus_if.busAddress,         32'd0);
        chk("rst_be",     32'(bus_if.busByteEnable), 32'd0);
        reset = 1'b1;
        tick();

        // Signed byte load, offset 3, ready in first ACCESS cycle
        bus_if.reqValid = 1'b1; bus_if.reqWrite = 1'b0; bus_if.reqSize = 2'b00;
        bus_if.reqSigned = 1'b1; bus_if.address = 32'h1000_0003; bus_if.dataSelectBits = 2'b11;
        bus_if.busReadData = 32'h80FF_FFFF; bus_if.busReady = 1'b1;
        tick();
        bus_if.reqValid = 1'b0;
        chk("b_rd",    32'(bus_if.busRead),       32'd1);
        chk("b_addr",  bus_if.busAddress,         32'h1000_0000);
        chk("b_be",    32'(bus_if.busByteEnable), 32'h8);
        chk("b_busy",  32'(bus_if.busy),          32'd1);
        tick();
        chk("b_rd_drop", 32'(bus_if.busRead),     32'd0);
        chk("b_done0",   32'(bus_if.done),        32'd0);
        tick();
        chk("b_done",  32'(bus_if.done),          32'd1);
        chk("b_load",  bus_if.loadData,           32'hFFFF_FF80);
        chk("b_idle",  32'(bus_if.busy),          32'd0);
        bus_if.busReady = 1'b0;
        tick();

        // Halfword store, offset 2, three wait cycles
        bus_if.reqValid = 1'b1; bus_if.reqWrite = 1'b1; bus_if.reqSize = 2'b01;
        bus_if.reqSigned = 1'b0; bus_if.address = 32'h2000_0006; bus_if.dataSelectBits = 2'b10;
        bus_if.writeData = 32'h0000_BEEF;
        tick();
        bus_if.reqValid = 1'b0;
        chk("h_be",    32'(bus_if.busByteEnable), 32'hC);
        chk("h_wd",    bus_if.busWriteData,       32'hBEEF_BEEF);
        chk("h_addr",  bus_if.busAddress,         32'h2000_0004);
        chk("h_rd",    32'(bus_if.busRead),       32'd0);
        chk("h_wr0",   32'(bus_if.busWrite),      32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("h_wr_hold", 32'(bus_if.busWrite), 32'd1);
            chk("h_nodone",  32'(bus_if.done),     32'd0);
        end
        bus_if.busReady = 1'b1;
        tick();
        chk("h_wr_drop", 32'(bus_if.busWrite),    32'd0);
        bus_if.busReady = 1'b0;
        tick();
        chk("h_done",  32'(bus_if.done),          32'd1);
        chk("h_load",  bus_if.loadData,           32'hFFFF_FF80);
        tick();

        // Misaligned word load and reserved size
        bus_if.reqValid = 1'b1; bus_if.reqWrite = 1'b0; bus_if.reqSize = 2'b10;
        bus_if.address = 32'h3000_0002; bus_if.dataSelectBits = 2'b10;
        tick();
        bus_if.reqValid = 1'b0;
        chk("a_fault", 32'(bus_if.alignFault),    32'd1);
        chk("a_done",  32'(bus_if.done),          32'd1);
        chk("a_rd",    32'(bus_if.busRead),       32'd0);
        chk("a_busy",  32'(bus_if.busy),          32'd0);
        chk("a_load",  bus_if.loadData,           32'hFFFF_FF80);
        tick();
        chk("a_clear", 32'(bus_if.alignFault),    32'd0);
        bus_if.reqValid = 1'b1; bus_if.reqSize = 2'b11; bus_if.dataSelectBits = 2'b00;
        tick();
        bus_if.reqValid = 1'b0;
        chk("r_fault", 32'(bus_if.alignFault),    32'd1);
        chk("r_rd",    32'(bus_if.busRead),       32'd0);
        tick();

        // Timeout: busReady never rises, TIMEOUT=4
        bus_if.reqValid = 1'b1; bus_if.reqSize = 2'b00; bus_if.reqSigned = 1'b0;
        bus_if.address = 32'h4000_0000; bus_if.dataSelectBits = 2'b00;
        tick();
        bus_if.reqValid = 1'b0;
        chk("t_rd0",   32'(bus_if.busRead),       32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t_rd_hold", 32'(bus_if.busRead),  32'd1);
            chk("t_nofault", 32'(bus_if.busFault), 32'd0);
        end
        tick();
        chk("t_rd_drop", 32'(bus_if.busRead),     32'd0);
        chk("t_fault",   32'(bus_if.busFault),    32'd1);
        chk("t_done",    32'(bus_if.done),        32'd1);
        chk("t_load",    bus_if.loadData,         32'hFFFF_FF80);
        tick();
        chk("t_busy",    32'(bus_if.busy),        32'd0);
        chk("t_clear",   32'(bus_if.busFault),    32'd0);

        // Reset during the second ACCESS cycle, with busReady high
        bus_if.reqValid = 1'b1; bus_if.reqSize = 2'b10; bus_if.address = 32'h6000_0000;
        tick();
        bus_if.reqValid = 1'b0;
        tick();
        chk("x_rd_pre", 32'(bus_if.busRead),      32'd1);
        reset = 1'b0; bus_if.busReady = 1'b1;
        tick();
        chk("x_rd",    32'(bus_if.busRead),       32'd0);
        chk("x_busy",  32'(bus_if.busy),          32'd0);
        chk("x_done",  32'(bus_if.done),          32'd0);
        chk("x_load",  bus_if.loadData,           32'd0);
        chk("x_addr",  bus_if.busAddress,         32'd0);
        reset = 1'b1; bus_if.busReady = 1'b0;
        tick();
        chk("x_nodone", 32'(bus_if.done),         32'd0);

        // Back-to-back: unsigned halfword load then byte load
        bus_if.reqValid = 1'b1; bus_if.reqWrite = 1'b0; bus_if.reqSize = 2'b01;
        bus_if.reqSigned = 1'b0; bus_if.address = 32'h5000_0000; bus_if.dataSelectBits = 2'b00;
        bus_if.busReadData = 32'h1234_F00D; bus_if.busReady = 1'b1;
        tick();
        bus_if.reqValid = 1'b0;
        tick();
        tick();
        chk("bb_done1", 32'(bus_if.done),         32'd1);
        chk("bb_load1", bus_if.loadData,          32'h0000_F00D);
        bus_if.reqValid = 1'b1; bus_if.reqSize = 2'b00; bus_if.dataSelectBits = 2'b01;
        bus_if.address = 32'h5000_0001; bus_if.busReadData = 32'h0000_AB00;
        tick();
        bus_if.reqValid = 1'b0;
        chk("bb_acc2",  32'(bus_if.busRead),       32'd1);
        chk("bb_be2",   32'(bus_if.busByteEnable), 32'h2);
        tick();
        tick();
        chk("bb_done2", 32'(bus_if.done),          32'd1);
        chk("bb_load2", bus_if.loadData,           32'h0000_00AB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_interface.md
MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of busReady-low cycles in ACCESS before a bus fault (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port reqValid  input  1  access request strobe from the load/store sequencer.
REQ-005 SHALL have port reqWrite  input  1  1=store, 0=load.
REQ-006 SHALL have port reqSize  input  2  00=byte, 01=halfword, 10=word, 11=reserved.
REQ-007 SHALL have port reqSigned  input  1  1=sign-extend load data, 0=zero-extend.
REQ-008 SHALL have port address  input  32  registered access address from the address unit.
REQ-009 SHALL have port dataSelectBits  input  2  registered byte offset from the address unit.
REQ-010 SHALL have port writeData  input  32  store data, right-justified.
REQ-011 SHALL have port busReadData  input  32  external bus read word.
REQ-012 SHALL have port busReady  input  1  external bus completion, sampled every ACCESS cycle.
REQ-013 SHALL have outputs busAddress (32), busByteEnable (4), busWriteData (32), busRead (1) and busWrite (1), all registered.
REQ-014 SHALL have outputs busy (1), done (1), loadData (32), alignFault (1) and busFault (1), all registered.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS and RESPOND; busy SHALL be 1 in ACCESS and RESPOND only.
REQ-016 SHALL accept a request only in IDLE with reqValid=1; reqValid in other states is ignored, and the requester holds it.
REQ-017 SHALL take the byte offset from dataSelectBits, never from address[1:0].
REQ-018 SHALL flag misalignment for halfword with offset 1 or 3, word with offset other than 0, or reqSize=11.
REQ-019 On a misaligned accept, SHALL pulse alignFault and done together one cycle later, stay in IDLE, issue no bus strobe, and leave loadData unchanged.
REQ-020 On an aligned accept, SHALL enter ACCESS next cycle with busAddress={address[31:2],2'b00} and busRead=~reqWrite, busWrite=reqWrite.
REQ-021 Byte enables: byte = 0001 shifted left by offset; halfword = 0011 (offset 0) or 1100 (offset 2); word = 1111.
REQ-022 busWriteData SHALL be {4{writeData[7:0]}} for byte, {2{writeData[15:0]}} for halfword, and writeData for word.
REQ-023 Bus outputs SHALL hold constant throughout ACCESS.
REQ-024 On busReady=1 in ACCESS, SHALL drop busRead/busWrite and enter RESPOND on the next edge.
REQ-025 In RESPOND, SHALL pulse done for one cycle and return to IDLE.
REQ-026 For loads, loadData SHALL be updated in the RESPOND cycle with the selected byte/halfword of busReadData, extended to 32 bits per the latched reqSigned.
REQ-027 For stores, loadData SHALL be unchanged.
REQ-028 Minimum accept-to-done latency SHALL be 2 cycles (busReady=1 in the first ACCESS cycle); each wait cycle adds 1.
REQ-029 SHALL run an 8-bit wait counter that clears on entering ACCESS and increments on each busReady-low ACCESS cycle.
REQ-030 When the wait counter reaches TIMEOUT, SHALL drop strobes, pulse busFault and done together next cycle, return to IDLE, and leave loadData unchanged.
REQ-031 busReady=1 in the same cycle the counter reaches TIMEOUT SHALL count as success; no busFault.
REQ-032 A new request SHALL be acceptable in the cycle after done; back-to-back throughput is 1 access per 3 cycles minimum.

Reset
REQ-033 With reset=0 at a rising edge, SHALL force state IDLE, the wait counter to 0, and every output to 0.
REQ-034 Reset mid-ACCESS or mid-RESPOND SHALL drop bus strobes at that edge and suppress done, alignFault and busFault.
REQ-035 Reset SHALL take priority over reqValid and busReady in the same cycle.

Verification
REQ-036 Byte load, signed: address=0x1000_0003, offset=3, busReadData=0x80FF_FFFF, busReady=1 first cycle -> busByteEnable=1000, busAddress=0x1000_0000, done 2 cycles after accept, loadData=0xFFFF_FF80.
REQ-037 Halfword store: offset=2, writeData=0x0000_BEEF, 3 wait cycles -> busWrite held 4 cycles, busByteEnable=1100, busWriteData=0xBEEF_BEEF, done at cycle 5, loadData unchanged.
REQ-038 Word load, offset=2 -> alignFault=done=1 one cycle after accept, busRead never asserted.
REQ-039 TIMEOUT=4, busReady held 0 -> busRead high 4 cycles, then busFault=done=1 pulse, busy=0 next cycle.
REQ-040 Reset asserted during the 2nd ACCESS cycle of a load -> all outputs 0 at the next edge, no done pulse.
REQ-041 Back-to-back halfword load (offset 0, unsigned, data 0x1234_F00D) then byte load -> loadData=0x0000_F00D, second request accepted the cycle after the first done.
